rr_pe_arbiter_w512: RTL and testbench
=====================================

// Module: rr_pe_arbiter_w512
// PURPOSE
//   Round-robin arbiter that shares one resource among N requesters.
//   Built around two simple lowest-index-first priority encoders: one on the
//   pointer-masked request vector, one on the raw vector.
//   A rotating priority pointer gives fairness. The grant is registered and
//   held until the owner releases it.
//   Sits between the request sources and the shared datapath or resource port.
// PARAMETERS
//   N      512             number of requesters; must be >= 2
//   PTR_W  $clog2(N)       width of the priority pointer and grant index
// PORTS
//   clk       in   1      single clock; all state is updated on its rising edge
//   rst_n     in   1      asynchronous reset, active-low
//   Req       in   N      request vector; bit i = requester i wants the resource
//   Done      in   1      single-cycle release pulse from the current owner
//   ptr_load  in   1      load the priority pointer from ptr_val
//   ptr_val   in   PTR_W  new pointer value, i.e. the index with highest priority
//   Gnt       out  N      registered one-hot grant; all zero when not granted
//   gnt_idx   out  PTR_W  binary index of the set Gnt bit; 0 when idle
//   valid     out  1      high while a grant is held (equals |Gnt)
//   ptr       out  PTR_W  current priority pointer, for debug and configuration readback
// BEHAVIOUR
//   Reset (rst_n low, asynchronous): Gnt=0, gnt_idx=0, valid=0, ptr=0, FSM=IDLE.
//     Reset asserted mid-grant drops Gnt immediately. No release is recorded.
//   Arbitration (combinational, evaluated in IDLE only):
//     mask[i]  = (i >= ptr)
//     m_req    = Req & mask
//     Winner   = lowest set bit of m_req if m_req != 0, else lowest set bit of Req.
//     Both priority encoders are the pre_req-chain style.
//   FSM, two states:
//     IDLE: if |Req, register Gnt = one-hot winner, gnt_idx = winner,
//       valid=1, next state BUSY. Latency is 1 cycle from Req to Gnt.
//       If Req == 0, stay in IDLE; outputs remain 0.
//     BUSY: hold Gnt, gnt_idx and valid stable; Req changes are ignored.
//       Release occurs when Done=1, or when Req[gnt_idx]=0 (owner withdrew).
//       On release:
//         - Gnt=0, valid=0, gnt_idx=0 on the next edge; next state IDLE.
//         - ptr <= (gnt_idx == N-1) ? 0 : gnt_idx+1  (wrap-around).
//     There is exactly one bubble cycle (IDLE) between consecutive grants.
//   Done in IDLE: ignored.
//   Pointer load: takes effect on the next edge in either state.
//     - If ptr_load coincides with a release, ptr_load wins over the
//       round-robin update.
//     - ptr_val >= N (only possible when N is not a power of two) loads 0.
//     - A load during BUSY does not disturb the held grant.
//   Simultaneous requests: exactly one bit of Gnt is ever set (one-hot or zero).
//   A requester that keeps Req high is granted again at most once per full
//   rotation while other requesters are pending.
//   Invariants, checked by assertions:
//     - valid == |Gnt
//     - $onehot0(Gnt)
//     - Gnt[gnt_idx] == valid
// TESTING  (bench at N=8 unless noted; N=512 smoke run required)
//   1. Reset, then Req=8'b0010_0100 with ptr=0
//      -> next cycle Gnt=8'b0000_0100, gnt_idx=2, valid=1.
//      Pulse Done -> Gnt=0 next cycle, ptr=3.
//   2. Req=8'hFF held, Done pulsed on each grant
//      -> grants 0,1,...,7,0 in order; ptr wraps 7->0 after the grant to 7.
//   3. ptr_load=1, ptr_val=6 while in IDLE, then Req=8'b0100_0010
//      -> grant 6. After release, Req=8'b0000_0010 -> grant 1 (masked set empty).
//   4. Grant 3 held, then Req[3] dropped with no Done
//      -> Gnt=0 next cycle, ptr=4. Changing other Req bits during BUSY
//         leaves Gnt unchanged.
//   5. Done and ptr_load (ptr_val=1) in the same cycle while owner is 5
//      -> ptr=1, not 6.
//   6. rst_n pulled low asynchronously mid-BUSY
//      -> Gnt, valid, ptr at 0 without waiting for a clock edge.
//      N=512: Req bit 511 only, ptr=511 -> grant 511, then ptr=0.

Source files
------------

// File: rtl/rr_pe_arbiter_w512.sv
// Round-robin arbiter for N requesters.
// Two lowest-index-first priority encoders (pointer-masked and raw requests)
// pick a winner while idle; the grant is registered and held until the owner
// releases it with Done or by withdrawing its request. The rotating pointer
// moves just past the released owner, so each requester gets its turn.
`timescale 1ns/1ps

// Invariant checker for the grant outputs, kept apart from the datapath.
module rr_pe_arbiter_w512_chk #(
  parameter int N     = 512,
  parameter int PTR_W = $clog2(N)
) (
  input logic             clk,
  input logic             rst_n,
  input logic [N-1:0]     gnt,
  input logic [PTR_W-1:0] gnt_idx,
  input logic             valid
);

  a_valid_matches_gnt: assert property (@(posedge clk) disable iff (!rst_n)
    valid == (|gnt));

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt));

  a_idx_matches_gnt: assert property (@(posedge clk) disable iff (!rst_n)
    gnt[gnt_idx] == valid);

endmodule

module rr_pe_arbiter_w512 #(
  parameter int N     = 512,
  parameter int PTR_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     Req,
  input  logic             Done,
  input  logic             ptr_load,
  input  logic [PTR_W-1:0] ptr_val,
  output logic [N-1:0]     Gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             valid,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [0:0]       ST_IDLE = 1'b0;
  localparam logic [0:0]       ST_BUSY = 1'b1;
  localparam logic [PTR_W-1:0] IDX_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] IDX_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] IDX_LAST = PTR_W'(N - 1);
  // One bit wider than the pointer so the comparison against N is exact
  // even when N is a power of two.
  localparam logic [PTR_W:0]   N_WIDE   = (PTR_W + 1)'(N);

  // Lowest-index-first priority encoder, pre_req chain style: a bit wins
  // only if no lower-index bit is requesting.
  function automatic logic [N-1:0] pe_lowest(input logic [N-1:0] req);
    logic [N:0]   pre_req;
    logic [N-1:0] oh;
    pre_req[0] = 1'b0;
    for (int i = 0; i < N; i++) begin
      oh[i]         = req[i] & ~pre_req[i];
      pre_req[i+1]  = pre_req[i] | req[i];
    end
    return oh;
  endfunction

  // One-hot (or zero) vector to binary index; zero maps to index 0.
  function automatic logic [PTR_W-1:0] oh_to_idx(input logic [N-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = IDX_ZERO;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) begin
        idx = idx | PTR_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [0:0]       state_r;
  logic [N-1:0]     gnt_r;
  logic [PTR_W-1:0] gnt_idx_r;
  logic             valid_r;
  logic [PTR_W-1:0] ptr_r;

  logic [N-1:0]     mask_s;
  logic [N-1:0]     m_req_s;
  logic [N-1:0]     m_oh_s;
  logic [N-1:0]     r_oh_s;
  logic [N-1:0]     win_oh_s;
  logic [PTR_W-1:0] win_idx_s;
  logic             release_s;
  logic [PTR_W-1:0] ptr_load_val_s;

  logic [0:0]       state_nxt_s;
  logic [N-1:0]     gnt_nxt_s;
  logic [PTR_W-1:0] gnt_idx_nxt_s;
  logic             valid_nxt_s;
  logic [PTR_W-1:0] ptr_nxt_s;

  // Winner selection: masked requests (index >= ptr) first, raw requests otherwise.
  always_comb begin
    mask_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      mask_s[i] = (32'(i) >= 32'(ptr_r));
    end
    m_req_s = Req & mask_s;
    m_oh_s  = pe_lowest(m_req_s);
    r_oh_s  = pe_lowest(Req);
    if (|m_req_s) begin
      win_oh_s = m_oh_s;
    end else begin
      win_oh_s = r_oh_s;
    end
    win_idx_s = oh_to_idx(win_oh_s);
  end

  // Pointer value used by a load; out-of-range values fall back to 0.
  always_comb begin
    if ({1'b0, ptr_val} >= N_WIDE) begin
      ptr_load_val_s = IDX_ZERO;
    end else begin
      ptr_load_val_s = ptr_val;
    end
  end

  // Next-state logic: grant from IDLE, hold or release in BUSY, pointer update.
  always_comb begin
    state_nxt_s   = state_r;
    gnt_nxt_s     = gnt_r;
    gnt_idx_nxt_s = gnt_idx_r;
    valid_nxt_s   = valid_r;
    ptr_nxt_s     = ptr_r;
    release_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|Req) begin
          gnt_nxt_s     = win_oh_s;
          gnt_idx_nxt_s = win_idx_s;
          valid_nxt_s   = 1'b1;
          state_nxt_s   = ST_BUSY;
        end else begin
          gnt_nxt_s     = {N{1'b0}};
          gnt_idx_nxt_s = IDX_ZERO;
          valid_nxt_s   = 1'b0;
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_BUSY: begin
        release_s = Done | ~Req[gnt_idx_r];
        if (release_s) begin
          gnt_nxt_s     = {N{1'b0}};
          gnt_idx_nxt_s = IDX_ZERO;
          valid_nxt_s   = 1'b0;
          state_nxt_s   = ST_IDLE;
          if (gnt_idx_r == IDX_LAST) begin
            ptr_nxt_s = IDX_ZERO;
          end else begin
            ptr_nxt_s = gnt_idx_r + IDX_ONE;
          end
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: begin
        gnt_nxt_s     = {N{1'b0}};
        gnt_idx_nxt_s = IDX_ZERO;
        valid_nxt_s   = 1'b0;
        state_nxt_s   = ST_IDLE;
      end
    endcase
    // An explicit load overrides the round-robin advance.
    if (ptr_load) begin
      ptr_nxt_s = ptr_load_val_s;
    end else begin
      ptr_nxt_s = ptr_nxt_s;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      gnt_r     <= {N{1'b0}};
      gnt_idx_r <= IDX_ZERO;
      valid_r   <= 1'b0;
      ptr_r     <= IDX_ZERO;
    end else begin
      state_r   <= state_nxt_s;
      gnt_r     <= gnt_nxt_s;
      gnt_idx_r <= gnt_idx_nxt_s;
      valid_r   <= valid_nxt_s;
      ptr_r     <= ptr_nxt_s;
    end
  end

  assign Gnt     = gnt_r;
  assign gnt_idx = gnt_idx_r;
  assign valid   = valid_r;
  assign ptr     = ptr_r;

  rr_pe_arbiter_w512_chk #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .gnt     (gnt_r),
    .gnt_idx (gnt_idx_r),
    .valid   (valid_r)
  );

endmodule

// File: tb/tb_rr_pe_arbiter_w512.sv
// Bench for rr_pe_arbiter_w512: directed vector table at N=8, randomized
// run against a behavioural round-robin model, asynchronous reset sequence,
// and an N=512 smoke sequence on a second instance.
`timescale 1ns/1ps

module tb_rr_pe_arbiter_w512;

  logic clk;
  logic rst_n;

  // N=8 instance signals
  logic [7:0]   req8;
  logic         done8;
  logic         ld8;
  logic [2:0]   val8;
  logic [7:0]   gnt8;
  logic [2:0]   idx8;
  logic         vld8;
  logic [2:0]   ptr8;

  // N=512 instance signals
  logic [511:0] req5;
  logic         done5;
  logic         ld5;
  logic [8:0]   val5;
  logic [511:0] gnt5;
  logic [8:0]   idx5;
  logic         vld5;
  logic [8:0]   ptr5;

  int n_cmp;
  int n_bad;

  rr_pe_arbiter_w512 #(.N(8), .PTR_W(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .Req(req8), .Done(done8), .ptr_load(ld8),
    .ptr_val(val8), .Gnt(gnt8), .gnt_idx(idx8), .valid(vld8), .ptr(ptr8)
  );

  rr_pe_arbiter_w512 #(.N(512), .PTR_W(9)) dut512 (
    .clk(clk), .rst_n(rst_n), .Req(req5), .Done(done5), .ptr_load(ld5),
    .ptr_val(val5), .Gnt(gnt5), .gnt_idx(idx5), .valid(vld5), .ptr(ptr5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic       ld;
    logic [2:0] val;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic [2:0] ptr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] req, input logic done, input logic ld,
                     input logic [2:0] val, input logic [7:0] gnt,
                     input logic [2:0] idx, input logic vld, input logic [2:0] ptr);
    vec_t v;
    v.req = req; v.done = done; v.ld = ld; v.val = val;
    v.gnt = gnt; v.idx = idx; v.vld = vld; v.ptr = ptr;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] g, input logic [2:0] i,
                        input logic v, input logic [2:0] p);
    check({tag, ".gnt"},   512'(gnt8), 512'(g));
    check({tag, ".idx"},   512'(idx8), 512'(i));
    check({tag, ".valid"}, 512'(vld8), 512'(v));
    check({tag, ".ptr"},   512'(ptr8), 512'(p));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: scan from the pointer upward with wrap-around; first requester wins.
  function automatic int rr_winner(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      int j;
      j = (p + k) % 8;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int m_busy;
    int m_owner;
    int m_ptr;
    logic [7:0] r;
    logic       d;
    logic       l;
    logic [2:0] lv;
    logic [511:0] one_hot511;

    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req8 = 8'h00; done8 = 1'b0; ld8 = 1'b0; val8 = 3'd0;
    req5 = '0;    done5 = 1'b0; ld5 = 1'b0; val5 = 9'd0;

    #2;
    check8("reset", 8'h00, 3'd0, 1'b0, 3'd0);
    check("reset.gnt512", gnt5, 512'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Test 1: basic grant and release
    add(8'b0010_0100, 1'b0, 1'b0, 3'd0, 8'h04, 3'd2, 1'b1, 3'd0);
    add(8'b0010_0100, 1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 3'd3);
    add(8'h00,        1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 3'd3);
    // Test 2: all requesting, pointer reset to 0 first, grants 0..7,0
    add(8'h00,        1'b0, 1'b1, 3'd0, 8'h00, 3'd0, 1'b0, 3'd0);
    for (int k = 0; k < 9; k++) begin
      int kk;
      kk = k % 8;
      add(8'hFF, 1'b0, 1'b0, 3'd0, 8'h01 << kk, 3'(kk), 1'b1, 3'(kk));
      add(8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 3'((kk + 1) % 8));
    end
    // Test 3: pointer load then masked/unmasked selection
    add(8'h00,        1'b0, 1'b1, 3'd6, 8'h00, 3'd0, 1'b0, 3'd6);
    add(8'b0100_0010, 1'b0, 1'b0, 3'd0, 8'h40, 3'd6, 1'b1, 3'd6);
    add(8'b0100_0010, 1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 3'd7);
    add(8'b0000_0010, 1'b0, 1'b0, 3'd0, 8'h02, 3'd1, 1'b1, 3'd7);
    add(8'b0000_0010, 1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 3'd2);
    // Test 4: owner withdraws; other Req changes during BUSY ignored
    add(8'h08,        1'b0, 1'b0, 3'd0, 8'h08, 3'd3, 1'b1, 3'd2);
    add(8'h0F,        1'b0, 1'b0, 3'd0, 8'h08, 3'd3, 1'b1, 3'd2);
    add(8'hF7,        1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 3'd4);
    // Test 5: load beats round-robin advance on release
    add(8'h20,        1'b0, 1'b0, 3'd0, 8'h20, 3'd5, 1'b1, 3'd4);
    add(8'h20,        1'b1, 1'b1, 3'd1, 8'h00, 3'd0, 1'b0, 3'd1);
    // Done in IDLE ignored; load during BUSY keeps the grant
    add(8'h00,        1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 3'd1);
    add(8'h04,        1'b0, 1'b0, 3'd0, 8'h04, 3'd2, 1'b1, 3'd1);
    add(8'h04,        1'b0, 1'b1, 3'd5, 8'h04, 3'd2, 1'b1, 3'd5);
    add(8'h04,        1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 3'd3);

    for (int i = 0; i < tbl.size(); i++) begin
      req8 = tbl[i].req; done8 = tbl[i].done; ld8 = tbl[i].ld; val8 = tbl[i].val;
      tick();
      check8($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].idx, tbl[i].vld, tbl[i].ptr);
    end
    req8 = 8'h00; done8 = 1'b0; ld8 = 1'b0; val8 = 3'd0;

    // Randomized run against the behavioural model (starts idle, ptr=3)
    m_busy = 0; m_owner = 0; m_ptr = 3;
    for (int c = 0; c < 400; c++) begin
      r  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) r = 8'h00;
      if (m_busy != 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
      d  = ($urandom_range(0, 3) == 0);
      l  = ($urandom_range(0, 15) == 0);
      lv = 3'($urandom_range(0, 7));
      req8 = r; done8 = d; ld8 = l; val8 = lv;
      if (m_busy != 0) begin
        if (d || !r[m_owner]) begin
          m_busy = 0;
          m_ptr  = (m_owner + 1) % 8;
        end
      end else if (r != 8'h00) begin
        m_owner = rr_winner(r, m_ptr);
        m_busy  = 1;
      end
      if (l) m_ptr = int'(lv);
      tick();
      check8($sformatf("rand%0d", c),
             (m_busy != 0) ? (8'h01 << m_owner) : 8'h00,
             (m_busy != 0) ? 3'(m_owner) : 3'd0,
             (m_busy != 0), 3'(m_ptr));
    end
    req8 = 8'h00; done8 = 1'b0; ld8 = 1'b0;
    tick();

    // Test 6: asynchronous reset in the middle of a grant
    req8 = 8'h10;
    tick();
    check("pre_reset.gnt", 512'(gnt8), 512'(8'h10));
    #2;
    rst_n = 1'b0;
    #1;
    check8("async_reset", 8'h00, 3'd0, 1'b0, 3'd0);
    req8 = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // N=512 smoke: pointer 511, only requester 511
    ld5 = 1'b1; val5 = 9'd511;
    tick();
    ld5 = 1'b0;
    check("w512.ptr_load", 512'(ptr5), 512'(9'd511));
    one_hot511 = '0;
    one_hot511[511] = 1'b1;
    req5 = one_hot511;
    tick();
    check("w512.gnt",   gnt5, one_hot511);
    check("w512.idx",   512'(idx5), 512'(9'd511));
    check("w512.valid", 512'(vld5), 512'(1'b1));
    done5 = 1'b1;
    tick();
    done5 = 1'b0;
    req5 = '0;
    check("w512.rel_gnt",   gnt5, 512'd0);
    check("w512.rel_valid", 512'(vld5), 512'(1'b0));
    check("w512.ptr_wrap",  512'(ptr5), 512'(9'd0));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
